display_arbiter: RTL and testbench

DISPLAY_ARBITER -- requirements
Module: display_arbiter

---
 rtl/disp_pkg.sv | 30 +++
 rtl/dwell_timer.sv | 33 +++
 rtl/display_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_display_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared state encoding, idle word and grant helpers for display_arbiter.
// The BLANK state exists only when DISP_ARB_BLANK_EN is defined.
package disp_pkg;

`ifdef DISP_ARB_BLANK_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN0  = 2'd1,
        ST_OWN1  = 2'd2,
        ST_BLANK = 2'd3
    } disp_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } disp_state_e;
`endif

    localparam logic [15:0] IDLE_WORD = 16'h0000;

    function automatic disp_state_e own_state(input logic who);
        return who ? ST_OWN1 : ST_OWN0;
    endfunction

    function automatic logic [1:0] grant_of(input logic who);
        return who ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Loadable down-counter that saturates at zero; zero flag is combinational from the count.
module dwell_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/display_arbiter.sv
// Round-robin owner of a four-digit hex display with a minimum dwell per grant.
// Defining DISP_ARB_BLANK_EN inserts a dark BLANK interval between owners.
//   state | meaning
//   IDLE  | no owner, display dark
//   OWN0  | requester 0 owns the display
//   OWN1  | requester 1 owns the display
//   BLANK | dark gap before handing over to target_q
module display_arbiter #(
    parameter int unsigned DWELL_CYCLES = 50000000,
    parameter int unsigned BLANK_CYCLES = 5000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [15:0] word0,
    input  logic [15:0] word1,
    output logic [1:0]  grant,
    output logic [15:0] word2display,
    output logic        blank,
    output logic        busy
);
    import disp_pkg::*;

    localparam int unsigned DW = $clog2(DWELL_CYCLES + 1);
    localparam logic [DW-1:0] DWELL_LOAD = DW'(DWELL_CYCLES - 1);

    if (DWELL_CYCLES == 0 || BLANK_CYCLES == 0) begin : g_bad_param
        $error("display_arbiter: DWELL_CYCLES and BLANK_CYCLES must be at least 1");
    end

    disp_state_e state_q, state_d;
    logic        ptr_q, ptr_d;
    logic [1:0]  grant_q, grant_d;
    logic [15:0] word_q, word_d;
    logic        blank_q, blank_d;
    logic        busy_q, busy_d;
    logic        dwell_load, dwell_zero;
    logic        take, who, owner;

    dwell_timer #(.WIDTH(DW)) u_dwell (
        .clk      (clk),
        .rst      (rst),
        .load     (dwell_load),
        .load_val (DWELL_LOAD),
        .zero     (dwell_zero)
    );

`ifdef DISP_ARB_BLANK_EN
    localparam int unsigned BW = $clog2(BLANK_CYCLES + 1);
    localparam logic [BW-1:0] BLANK_LOAD = BW'(BLANK_CYCLES - 1);

    logic target_q, target_d, blank_load, blank_zero;

    dwell_timer #(.WIDTH(BW)) u_blank (
        .clk      (clk),
        .rst      (rst),
        .load     (blank_load),
        .load_val (BLANK_LOAD),
        .zero     (blank_zero)
    );
`endif

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        word_d     = word_q;
        blank_d    = blank_q;
        busy_d     = busy_q;
        dwell_load = 1'b0;
        take       = 1'b0;
        who        = 1'b0;
        owner      = (state_q == ST_OWN1);
`ifdef DISP_ARB_BLANK_EN
        target_d   = target_q;
        blank_load = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    take = 1'b1;
                    who  = (req == 2'b11) ? ptr_q : req[1];
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (dwell_zero) begin
                    if (req[~owner]) begin
`ifdef DISP_ARB_BLANK_EN
                        state_d    = ST_BLANK;
                        target_d   = ~owner;
                        blank_load = 1'b1;
`else
                        take = 1'b1;
                        who  = ~owner;
`endif
                    end else if (!req[owner]) begin
                        state_d = ST_IDLE;
                    end
                end
            end
`ifdef DISP_ARB_BLANK_EN
            ST_BLANK: begin
                // Fall back to the previous owner if the target gave up during the gap
                if (blank_zero) begin
                    if (req[target_q]) begin
                        take = 1'b1;
                        who  = target_q;
                    end else if (req[~target_q]) begin
                        take = 1'b1;
                        who  = ~target_q;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        if (take) begin
            state_d    = own_state(who);
            ptr_d      = ~who;
            dwell_load = 1'b1;
        end

        // Outputs follow the next state; the word tracks the owner from its second cycle on
        case (state_d)
            ST_OWN0, ST_OWN1: begin
                grant_d = grant_of(state_d == ST_OWN1);
                blank_d = 1'b0;
                busy_d  = take || !dwell_zero;
                if (state_q == state_d) begin
                    word_d = (state_d == ST_OWN1) ? word1 : word0;
                end
            end
`ifdef DISP_ARB_BLANK_EN
            ST_BLANK: begin
                grant_d = 2'b00;
                blank_d = 1'b1;
                busy_d  = 1'b0;
            end
`endif
            default: begin
                grant_d = 2'b00;
                word_d  = IDLE_WORD;
                blank_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= 1'b0;
            grant_q  <= 2'b00;
            word_q   <= IDLE_WORD;
            blank_q  <= 1'b1;
            busy_q   <= 1'b0;
`ifdef DISP_ARB_BLANK_EN
            target_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            word_q   <= word_d;
            blank_q  <= blank_d;
            busy_q   <= busy_d;
`ifdef DISP_ARB_BLANK_EN
            target_q <= target_d;
`endif
        end
    end

    assign grant        = grant_q;
    assign word2display = word_q;
    assign blank        = blank_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Self-checking bench for display_arbiter: cycle model compare plus directed literal checks.
`timescale 1ns/1ps
module tb_display_arbiter;

    localparam int DWELL  = 4;
    localparam int BLANKC = 2;

    logic        clk, rst;
    logic [1:0]  req;
    logic [15:0] word0, word1, word2display;
    logic [1:0]  grant;
    logic        blank, busy;

    int n_tests = 0;
    int n_fail  = 0;

    display_arbiter #(.DWELL_CYCLES(DWELL), .BLANK_CYCLES(BLANKC)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .word0        (word0),
        .word1        (word1),
        .grant        (grant),
        .word2display (word2display),
        .blank        (blank),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: phase 0 idle, 1 owned, 2 blanking; age counts cycles shown to the owner
    int m_st = 0, m_own = 0, m_ptr = 0, m_age = 0, m_bage = 0, m_tgt = 0;
    logic [1:0]  e_grant = 2'b00;
    logic [15:0] e_word  = 16'h0000;
    logic        e_blank = 1'b1, e_busy = 1'b0;

    task automatic grant_to(input int w);
        m_st  = 1;
        m_own = w;
        m_ptr = 1 - w;
        m_age = 1;
    endtask

    always @(posedge clk) begin
        int prev_st, prev_own;
        logic [1:0]  r;
        logic [15:0] w0, w1;
        r = req; w0 = word0; w1 = word1;
        prev_st = m_st; prev_own = m_own;
        if (!rst) begin
            m_st = 0; m_ptr = 0; m_own = 0; m_age = 0; m_bage = 0;
        end else begin
            case (m_st)
                0: begin
                    if (r == 2'b11) grant_to(m_ptr);
                    else if (r != 2'b00) grant_to(int'(r[1]));
                end
                1: begin
                    if (m_age < DWELL) m_age++;
                    else if (r[1 - m_own]) begin
`ifdef DISP_ARB_BLANK_EN
                        m_st = 2; m_tgt = 1 - m_own; m_bage = 1;
`else
                        grant_to(1 - m_own);
`endif
                    end else if (r[m_own]) m_age = DWELL + 1;
                    else m_st = 0;
                end
                default: begin
                    if (m_bage < BLANKC) m_bage++;
                    else if (r[m_tgt]) grant_to(m_tgt);
                    else if (r[1 - m_tgt]) grant_to(1 - m_tgt);
                    else m_st = 0;
                end
            endcase
        end
        if (m_st == 0) begin
            e_grant = 2'b00; e_word = 16'h0000; e_blank = 1'b1; e_busy = 1'b0;
        end else if (m_st == 1) begin
            e_grant = (m_own == 1) ? 2'b10 : 2'b01;
            e_blank = 1'b0;
            e_busy  = (m_age <= DWELL);
            if (prev_st == 1 && prev_own == m_own) e_word = (m_own == 1) ? w1 : w0;
        end else begin
            e_grant = 2'b00; e_blank = 1'b1; e_busy = 1'b0;
        end
        #1;
        chk("cycle_model", {12'h0, grant, word2display, blank, busy},
                           {12'h0, e_grant, e_word, e_blank, e_busy});
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input logic [1:0] r);
        rst = 1'b0; req = r;
        cyc(2);
        rst = 1'b1;
    endtask

    logic [1:0] gr [0:31];
    logic       bl [0:31];
    int hold, idx, nb, busy_cnt, nrun;
    logic [1:0] run_own [0:3];
    int         run_len [0:3];

    initial begin
        rst = 1'b0; req = 2'b00; word0 = 16'h0000; word1 = 16'h0000;

        // reset with both requesting, then first grant goes to requester 0
        word0 = 16'h1234; word1 = 16'hABCD;
        req = 2'b11;
        cyc(2);
        chk("rst_grant", grant, 2'b00);
        chk("rst_word", word2display, 16'h0000);
        chk("rst_blank", blank, 1'b1);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b1;
        cyc(1);
        chk("first_grant", grant, 2'b01);

        // single requester: word follows one cycle after grant, busy for DWELL cycles
        do_reset(2'b01);
        word0 = 16'h1234;
        cyc(1);
        chk("single_grant", grant, 2'b01);
        chk("entry_word", word2display, 16'h0000);
        busy_cnt = int'(busy);
        cyc(1);
        chk("follow_word", word2display, 16'h1234);
        busy_cnt += int'(busy);
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            busy_cnt += int'(busy);
        end
        chk("busy_len", busy_cnt, DWELL);
        word0 = 16'h5A5A;
        cyc(1);
        chk("live_follow", word2display, 16'h5A5A);

        // owner 0, requester 1 arrives early in the dwell
        do_reset(2'b01);
        cyc(1);
        req = 2'b11;
        gr[0] = grant; bl[0] = blank;
        for (int i = 1; i < 12; i++) begin
            cyc(1);
            gr[i] = grant; bl[i] = blank;
        end
        hold = 0;
        while (hold < 10 && gr[hold] == 2'b01) hold++;
        chk("dwell_hold", hold, DWELL);
`ifdef DISP_ARB_BLANK_EN
        nb = 0; idx = hold;
        while (idx < 10 && gr[idx] == 2'b00 && bl[idx]) begin nb++; idx++; end
        chk("blank_len", nb, BLANKC);
        chk("after_blank", gr[idx], 2'b10);
`else
        chk("direct_switch", gr[hold], 2'b10);
        chk("no_blank", bl[hold], 1'b0);
`endif

        // owner 1 drops its request mid-dwell
        do_reset(2'b10);
        word1 = 16'hBEEF;
        cyc(1);
        chk("own1_grant", grant, 2'b10);
        cyc(1);
        req = 2'b00;
        cyc(1);
        chk("drop_word", word2display, 16'hBEEF);
        cyc(1);
        chk("drop_hold", grant, 2'b10);
        cyc(1);
        chk("drop_idle", grant, 2'b00);
        chk("drop_idle_word", word2display, 16'h0000);
        chk("drop_idle_blank", blank, 1'b1);

        // fairness with both requesting continuously
        do_reset(2'b11);
        for (int i = 0; i < 24; i++) begin
            cyc(1);
            gr[i] = grant;
        end
        nrun = 0;
        for (int i = 0; i < 24; i++) begin
            if (gr[i] != 2'b00) begin
                if (i == 0 || gr[i] != gr[i-1]) begin
                    if (nrun < 4) begin run_own[nrun] = gr[i]; run_len[nrun] = 0; end
                    nrun++;
                end
                if (nrun <= 4) run_len[nrun-1]++;
            end
        end
        chk("fair_runs", int'(nrun >= 3), 1);
        chk("fair_own0", run_own[0], 2'b01);
        chk("fair_own1", run_own[1], 2'b10);
        chk("fair_own2", run_own[2], 2'b01);
        chk("fair_len0", run_len[0], DWELL);
        chk("fair_len1", run_len[1], DWELL);

        // reset during the hand-over window clears the pointer
        do_reset(2'b11);
        cyc(5);
        rst = 1'b0;
        cyc(1);
        chk("midrst_grant", grant, 2'b00);
        chk("midrst_blank", blank, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_word", word2display, 16'h0000);
        rst = 1'b1;
        cyc(1);
        chk("midrst_ptr", grant, 2'b01);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cyc(1);
            rst   = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 7) == 0) req = 2'($urandom_range(0, 3));
            word0 = 16'($urandom);
            word1 = 16'($urandom);
        end
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
